// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for an N-digit 7-segment panel. Each
// digit gets a slot of SCAN_DIV clock cycles. The first GUARD cycles of every
// slot keep all digits dark, so the previous digit's segments cannot ghost
// onto the next one. Digits come from one of NUM_PAGES pages of BCD data.
// The page is latched only at frame boundaries, which prevents tearing
// between pages. Per-digit blank and blink masks suppress individual digits.
//
// Ports:
//   clk_in      - system clock
//   rst         - synchronous active-high reset
//   digits_in   - BCD digits, page p / digit d at [(p*NUM_DIGITS+d)*4 +: 4]
//   page_sel    - requested page (out-of-range values fall back to page 0)
//   blank_mask  - 1 = digit always dark
//   blink_mask  - 1 = digit blinks while blink_en is high
//   blink_en    - global blink enable
//   seg_out     - segments {g,f,e,d,c,b,a}, active-low
//   dig_sel     - digit enables, active-low one-hot (all ones = off)
//   frame_start - one-cycle pulse when digit 0's slot begins
//   blink_phase - 1 = blinking digits currently hidden
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int NUM_PAGES  = 2,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 1,
    parameter int BLINK_DIV  = 500000,
    parameter int PW         = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                              clk_in,
    input  logic                              rst,
    input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] digits_in,
    input  logic [PW-1:0]                     page_sel,
    input  logic [NUM_DIGITS-1:0]             blank_mask,
    input  logic [NUM_DIGITS-1:0]             blink_mask,
    input  logic                              blink_en,
    output logic [6:0]                        seg_out,
    output logic [NUM_DIGITS-1:0]             dig_sel,
    output logic                              frame_start,
    output logic                              blink_phase
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DW = $clog2(NUM_DIGITS);

    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] dig_idx;
    logic [PW-1:0] page_lat;
    logic [BW-1:0] blink_cnt;

    logic       scan_wrap;
    logic       last_digit;
    logic       frame_wrap;
    logic       blink_wrap;
    logic       page_ok;
    logic       in_guard;
    logic       suppress;
    logic [3:0] cur_digit;
    logic [6:0] cur_seg;

    assign scan_wrap  = (scan_cnt == SW'(SCAN_DIV - 1));
    assign last_digit = (dig_idx == DW'(NUM_DIGITS - 1));
    assign frame_wrap = scan_wrap && last_digit;
    assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));

    // The extra leading bit lets the compare represent NUM_PAGES itself,
    // even when NUM_PAGES is a power of two.
    assign page_ok = ({1'b0, page_sel} < (PW + 1)'(NUM_PAGES));

    // A zero-length guard would make the compare constant, so it is split out.
    if (GUARD == 0) begin : g_no_guard
        assign in_guard = 1'b0;
    end else begin : g_guard
        assign in_guard = (scan_cnt < SW'(GUARD));
    end

    // Blank has priority. Blink hides a digit only in the hidden phase.
    assign suppress = blank_mask[dig_idx] ||
                      (blink_en && blink_mask[dig_idx] && blink_phase);

    // Select the nibble for the current page and digit from the flat bus.
    always_comb begin
        cur_digit = 4'h0;
        for (int p = 0; p < NUM_PAGES; p++) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (page_lat == PW'(p) && dig_idx == DW'(d)) begin
                    cur_digit = digits_in[(p*NUM_DIGITS + d)*4 +: 4];
                end
            end
        end
    end

    // Active-low decode. 4'hF draws a dash; A..E are treated as blank.
    always_comb begin
        cur_seg = 7'h7F;
        case (cur_digit)
            4'h0:    cur_seg = 7'h40;
            4'h1:    cur_seg = 7'h79;
            4'h2:    cur_seg = 7'h24;
            4'h3:    cur_seg = 7'h30;
            4'h4:    cur_seg = 7'h19;
            4'h5:    cur_seg = 7'h12;
            4'h6:    cur_seg = 7'h02;
            4'h7:    cur_seg = 7'h78;
            4'h8:    cur_seg = 7'h00;
            4'h9:    cur_seg = 7'h10;
            4'hF:    cur_seg = 7'h3F;
            default: cur_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            scan_cnt    <= '0;
            dig_idx     <= '0;
            page_lat    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_out     <= 7'h7F;
            dig_sel     <= '1;
            frame_start <= 1'b0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);

            if (scan_wrap) begin
                dig_idx <= last_digit ? '0 : dig_idx + DW'(1);
            end

            // The page is captured only when the scan returns to digit 0,
            // so a whole frame always shows a single page.
            if (frame_wrap) begin
                page_lat <= page_ok ? page_sel : '0;
            end
            frame_start <= frame_wrap;

            if (!blink_en) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            if (in_guard) begin
                dig_sel <= '1;
                seg_out <= 7'h7F;
            end else begin
                dig_sel <= ~(NUM_DIGITS'(1) << dig_idx);
                seg_out <= suppress ? 7'h7F : cur_seg;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Directed bench for display_scan_ctrl with a small build: 4 digits,
// SCAN_DIV=4, GUARD=1 and BLINK_DIV=16. One frame is therefore 16 cycles.
// A second instance uses NUM_PAGES=3 to exercise an out-of-range page_sel.
//
// Timeline convention: after reset releases, "tick k" is the k-th rising
// edge. Outputs sampled after tick k reflect scan position c = k-1. At that
// position scan_cnt = c%4 and dig_idx = (c/4)%4.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic [31:0] digits_in;
    logic [0:0]  page_sel;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        blink_en;
    logic [6:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_start;
    logic        blink_phase;

    logic [47:0] digits_in3;
    logic [1:0]  page_sel3;
    logic [6:0]  seg_out3;
    logic [3:0]  dig_sel3;
    logic        frame_start3;
    logic        blink_phase3;

    int checks   = 0;
    int failures = 0;

    // Hand-derived expectations for page 0 = {3,2,1,0} and page 1 = {9,8,F,A}
    logic [3:0] sel_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_p0  [4] = '{7'h40, 7'h79, 7'h24, 7'h30};
    logic [6:0] seg_p1  [4] = '{7'h7F, 7'h3F, 7'h00, 7'h10};

    display_scan_ctrl #(
        .NUM_DIGITS(4), .NUM_PAGES(2), .SCAN_DIV(4), .GUARD(1), .BLINK_DIV(16)
    ) dut (
        .clk_in(clk_in), .rst(rst), .digits_in(digits_in), .page_sel(page_sel),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .blink_en(blink_en),
        .seg_out(seg_out), .dig_sel(dig_sel), .frame_start(frame_start),
        .blink_phase(blink_phase)
    );

    display_scan_ctrl #(
        .NUM_DIGITS(4), .NUM_PAGES(3), .SCAN_DIV(4), .GUARD(1), .BLINK_DIV(16)
    ) dut3 (
        .clk_in(clk_in), .rst(rst), .digits_in(digits_in3), .page_sel(page_sel3),
        .blank_mask(4'b0000), .blink_mask(4'b0000), .blink_en(1'b0),
        .seg_out(seg_out3), .dig_sel(dig_sel3), .frame_start(frame_start3),
        .blink_phase(blink_phase3)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset values of all outputs
    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (seg_out !== 7'h7F) begin
            failures++;
            $display("[TB] FAIL reset_seg: got %h expected 7f", seg_out);
        end
        checks++;
        if (dig_sel !== 4'hF) begin
            failures++;
            $display("[TB] FAIL reset_dig: got %h expected f", dig_sel);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_fs: got %b expected 0", frame_start);
        end
        checks++;
        if (blink_phase !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_bp: got %b expected 0", blink_phase);
        end
    endtask

    // One full frame of page 0 with guard cycles and frame_start
    task automatic test_scan();
        logic [3:0] exp_sel;
        logic [6:0] exp_seg;
        page_sel = 1'b0; blank_mask = 4'h0; blink_mask = 4'h0; blink_en = 1'b0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            tick();
            if (c % 4 == 0) begin
                exp_sel = 4'hF; exp_seg = 7'h7F;
            end else begin
                exp_sel = sel_tab[c/4]; exp_seg = seg_p0[c/4];
            end
            checks++;
            if (dig_sel !== exp_sel) begin
                failures++;
                $display("[TB] FAIL scan_dig c=%0d: got %h expected %h", c, dig_sel, exp_sel);
            end
            checks++;
            if (seg_out !== exp_seg) begin
                failures++;
                $display("[TB] FAIL scan_seg c=%0d: got %h expected %h", c, seg_out, exp_seg);
            end
            checks++;
            if (frame_start !== (c == 15)) begin
                failures++;
                $display("[TB] FAIL scan_fs c=%0d: got %b expected %b", c, frame_start, (c == 15));
            end
        end
    endtask

    // Mid-frame change waits for the boundary; change in boundary cycle is captured
    task automatic test_page_switch();
        logic [3:0] exp_sel;
        logic [6:0] exp_seg;
        page_sel = 1'b0;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 16; c++) begin
                tick();
                if (c % 4 == 0) begin
                    exp_sel = 4'hF; exp_seg = 7'h7F;
                end else begin
                    exp_sel = sel_tab[c/4];
                    exp_seg = (f == 2) ? seg_p1[c/4] : seg_p0[c/4];
                end
                checks++;
                if (dig_sel !== exp_sel) begin
                    failures++;
                    $display("[TB] FAIL page_dig f=%0d c=%0d: got %h expected %h", f, c, dig_sel, exp_sel);
                end
                checks++;
                if (seg_out !== exp_seg) begin
                    failures++;
                    $display("[TB] FAIL page_seg f=%0d c=%0d: got %h expected %h", f, c, seg_out, exp_seg);
                end
                checks++;
                if (frame_start !== (c == 15)) begin
                    failures++;
                    $display("[TB] FAIL page_fs f=%0d c=%0d: got %b expected %b", f, c, frame_start, (c == 15));
                end
                if (f == 1 && c == 5)  page_sel = 1'b1;
                if (f == 2 && c == 14) page_sel = 1'b0;
            end
        end
    endtask

    // NUM_PAGES=3 build: page 2 is shown, then page_sel=3 falls back to page 0
    task automatic test_out_of_range();
        logic [6:0] exp_seg;
        page_sel3 = 2'd2;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 16; c++) begin
                tick();
                if (c == 1) begin
                    exp_seg = (f == 1) ? 7'h19 : 7'h40;
                    checks++;
                    if (seg_out3 !== exp_seg) begin
                        failures++;
                        $display("[TB] FAIL oor_seg f=%0d: got %h expected %h", f, seg_out3, exp_seg);
                    end
                    checks++;
                    if (dig_sel3 !== 4'hE) begin
                        failures++;
                        $display("[TB] FAIL oor_dig f=%0d: got %h expected e", f, dig_sel3);
                    end
                end
                if (f == 1 && c == 5) page_sel3 = 2'd3;
            end
        end
    endtask

    // Digits 0,1 blink; phase toggles every 16 enabled cycles
    task automatic test_blink();
        logic [3:0] exp_sel;
        logic [6:0] exp_seg;
        logic       exp_bp;
        page_sel = 1'b0; blank_mask = 4'h0; blink_mask = 4'b0011; blink_en = 1'b1;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 16; c++) begin
                tick();
                if (c % 4 == 0) begin
                    exp_sel = 4'hF; exp_seg = 7'h7F;
                end else begin
                    exp_sel = sel_tab[c/4];
                    exp_seg = (f == 1 && c/4 < 2) ? 7'h7F : seg_p0[c/4];
                end
                exp_bp = 1'(((16*f + c + 1) / 16) % 2);
                checks++;
                if (dig_sel !== exp_sel) begin
                    failures++;
                    $display("[TB] FAIL blink_dig f=%0d c=%0d: got %h expected %h", f, c, dig_sel, exp_sel);
                end
                checks++;
                if (seg_out !== exp_seg) begin
                    failures++;
                    $display("[TB] FAIL blink_seg f=%0d c=%0d: got %h expected %h", f, c, seg_out, exp_seg);
                end
                checks++;
                if (blink_phase !== exp_bp) begin
                    failures++;
                    $display("[TB] FAIL blink_bp f=%0d c=%0d: got %b expected %b", f, c, blink_phase, exp_bp);
                end
            end
        end
    endtask

    // Continues from test_blink with blink_phase=1: disabling clears it next cycle
    task automatic test_blink_disable();
        blink_en = 1'b0;
        tick();
        checks++;
        if (blink_phase !== 1'b0) begin
            failures++;
            $display("[TB] FAIL disable_bp: got %b expected 0", blink_phase);
        end
        tick();
        checks++;
        if (seg_out !== 7'h40) begin
            failures++;
            $display("[TB] FAIL disable_seg: got %h expected 40", seg_out);
        end
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (blink_phase !== 1'b0) begin
            failures++;
            $display("[TB] FAIL disable_hold_bp: got %b expected 0", blink_phase);
        end
    endtask

    // Blank wins over blink in both phases; dig_sel still asserts
    task automatic test_blank_priority();
        blank_mask = 4'b1000; blink_mask = 4'b1000; blink_en = 1'b1;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 16; c++) begin
                tick();
                if (c == 13) begin
                    checks++;
                    if (seg_out !== 7'h7F) begin
                        failures++;
                        $display("[TB] FAIL prio_seg f=%0d: got %h expected 7f", f, seg_out);
                    end
                    checks++;
                    if (dig_sel !== 4'h7) begin
                        failures++;
                        $display("[TB] FAIL prio_dig f=%0d: got %h expected 7", f, dig_sel);
                    end
                end
                if (c == 9) begin
                    checks++;
                    if (seg_out !== 7'h24) begin
                        failures++;
                        $display("[TB] FAIL prio_d2_seg f=%0d: got %h expected 24", f, seg_out);
                    end
                end
            end
        end
        blank_mask = 4'h0; blink_mask = 4'h0; blink_en = 1'b0;
    endtask

    // Reset during digit 2's slot while page 1 is latched
    task automatic test_reset_mid_slot();
        page_sel = 1'b1;
        do_reset();
        for (int k = 1; k <= 26; k++) tick();
        checks++;
        if (dig_sel !== 4'hB || seg_out !== 7'h00) begin
            failures++;
            $display("[TB] FAIL midrst_pre: got %h/%h expected b/00", dig_sel, seg_out);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (seg_out !== 7'h7F || dig_sel !== 4'hF || frame_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_out: got %h/%h/%b expected 7f/f/0", seg_out, dig_sel, frame_start);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dig_sel !== 4'hF || seg_out !== 7'h7F) begin
            failures++;
            $display("[TB] FAIL midrst_guard: got %h/%h expected f/7f", dig_sel, seg_out);
        end
        tick();
        checks++;
        if (dig_sel !== 4'hE || seg_out !== 7'h40) begin
            failures++;
            $display("[TB] FAIL midrst_d0: got %h/%h expected e/40", dig_sel, seg_out);
        end
    endtask

    initial begin
        digits_in  = 32'h98FA_3210;
        digits_in3 = 48'h7654_98FA_3210;
        page_sel   = 1'b0;
        page_sel3  = 2'd0;
        blank_mask = 4'h0;
        blink_mask = 4'h0;
        blink_en   = 1'b0;

        test_reset();
        test_scan();
        test_page_switch();
        test_out_of_range();
        test_blink();
        test_blink_disable();
        test_blank_priority();
        test_reset_mid_slot();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Parametrised successor to the clock's display selector. Drives a time-multiplexed N-digit 7-segment panel from up to NUM_PAGES pages of BCD digits (time page, date page, and so on).
- Page select is frame-synchronous. Per-digit blank and blink masks replace fixed blink codes, with a programmable blink rate and anti-ghost guard cycles.
- Sits between the BCD counter/setting logic and the panel pins. Outputs are one shared segment bus plus one-hot digit enables.

Parameters:
- NUM_DIGITS, 8, digits on panel (2..16).
- NUM_PAGES, 2, selectable digit pages (1..8).
- SCAN_DIV, 1000, clk_in cycles per digit slot (>= GUARD+1).
- GUARD, 1, cycles at the start of each slot with all digits off (0..SCAN_DIV-1).
- BLINK_DIV, 500000, clk_in cycles per blink half-period (>= 1).
- PW, max(1, clog2(NUM_PAGES)), width of page_sel.

Ports:
- clk_in, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- digits_in, in, NUM_PAGES*NUM_DIGITS*4, BCD digits. Page p, digit d at bits [(p*NUM_DIGITS+d)*4 +: 4]. Digit 0 is rightmost.
- page_sel, in, PW, requested page.
- blank_mask, in, NUM_DIGITS, 1 = digit always blank.
- blink_mask, in, NUM_DIGITS, 1 = digit blinks when blink_en=1.
- blink_en, in, 1, global blink enable.
- seg_out, out, 7, segments {g,f,e,d,c,b,a}, active-low.
- dig_sel, out, NUM_DIGITS, digit enables, active-low one-hot (all 1 = off).
- frame_start, out, 1, one-cycle pulse when digit 0's slot begins.
- blink_phase, out, 1, current blink phase (1 = blinking digits hidden).

Behaviour:
- Reset (rst=1 at posedge): scan_cnt=0, dig_idx=0, page_lat=0, blink_cnt=0, blink_phase=0, seg_out=7'h7F, dig_sel all 1, frame_start=0. Reset mid-scan aborts the slot immediately, with no partial completion.
- Scan counter: scan_cnt runs 0..SCAN_DIV-1 and wraps.
  - On wrap, dig_idx advances by 1, going NUM_DIGITS-1 -> 0.
  - When dig_idx advances to 0, page_lat <= page_sel. If page_sel >= NUM_PAGES, page_lat <= 0.
  - frame_start pulses in the cycle after that advance.
  - page_sel changes mid-frame have no effect until the next frame boundary, so there is no tearing.
- Outputs: registered, 1-cycle latency from (scan_cnt, dig_idx, page_lat, masks, digits_in).
  - While scan_cnt < GUARD: dig_sel all 1, seg_out=7'h7F.
  - Otherwise: dig_sel[dig_idx]=0, all other bits 1.
- Segment decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). 4'hF = dash 3F. 4'hA..4'hE = blank 7F.
- Digit suppression: seg_out=7'h7F if blank_mask[dig_idx], or if (blink_en && blink_mask[dig_idx] && blink_phase). blank_mask has priority. dig_sel still asserts for suppressed digits.
- Blink timer:
  - While blink_en=0: blink_cnt held 0 and blink_phase held 0.
  - While blink_en=1: blink_cnt runs 0..BLINK_DIV-1; on wrap, blink_phase toggles.
  - The first BLINK_DIV cycles after enable are therefore visible.
  - blink_mask changes do not restart the timer.
- Width/arithmetic: scan_cnt width clog2(SCAN_DIV); blink_cnt width clog2(BLINK_DIV). No truncation at max parameter values.
- Simultaneous events: a frame boundary coinciding with a blink toggle applies both in the same cycle. A page_sel change in the boundary cycle is captured.

Test Plan:
- Params ND=4, NP=2, SCAN_DIV=4, GUARD=1, BLINK_DIV=16.
  - Page0 digits {3,2,1,0}, page_sel=0 -> dig_sel sequence E,D,B,7 (each preceded by one F guard cycle). seg_out 40,79,24,30. frame_start every 16 cycles.
  - Switch page_sel to 1 at cycle 6 of a frame, with page1 = {9,8,F,A} -> current frame still shows page0. The next frame shows 7F,3F,00,10.
  - page_sel=3 (out of range, PW=2 with NP=3 build) -> page_lat=0 at next frame.
- Blink:
  - blink_en=1, blink_mask=4'b0011 -> digits 0,1 normal for cycles 1..16 after enable, 7F for the next 16, and so on. Digits 2,3 are never blanked.
  - blink_en low -> blink_phase returns to 0 next cycle.
- blank_mask=4'b1000, blink_mask=4'b1000, blink_en=1 -> digit 3 always 7F regardless of phase.
- Assert rst mid-slot (dig_idx=2) -> next cycle seg_out=7F, dig_sel=F, frame_start=0. After release, scan restarts at digit 0 with page_lat=0.
